mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer with an architectural HI/LO register pair, placed in the E stage beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from E-stage decode and models fixed MIPS multiply/divide latency with a countdown.
- Drives a busy flag and a stall request to the hazard unit; muxes HI/LO onto the read-out bus for MFHI/MFLO.

---
 rtl/mdu_ctrl_if.sv | 22 ++
 rtl/mdu_ctrl.sv | 144 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_ctrl_if.sv
// Issue/result bundle between E-stage decode and the multiply/divide sequencer.
// The master drives the op and operands; the slave returns status, HI/LO and the read-out bus.
interface mdu_ctrl_if;
  logic [3:0]  op;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        busy;
  logic        stall;
  logic [31:0] out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op, inA, inB,
    input  busy, stall, out, hi, lo
  );

  modport slave (
    input  op, inA, inB,
    output busy, stall, out, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer with an architectural HI/LO pair and a fixed-latency
// countdown. Optional MADD (op=9) is enabled by defining MDU_MADD_EN.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMfhi  = 4'd5,
    OpMflo  = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8,
    OpMadd  = 4'd9
  } op_e;

  localparam logic [3:0] MulCnt = 4'(MUL_LAT);
  localparam logic [3:0] DivCnt = 4'(DIV_LAT);

  op_e         op;
  logic [31:0] a, b;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy, op_valid;

  assign op   = op_e'(bus.op);
  assign a    = bus.inA;
  assign b    = bus.inB;
  assign busy = (cnt_q != 4'd0);

  // One 64-bit multiplier; operands are sign-extended only for signed ops.
  logic        mul_signed;
  logic [63:0] prod;
  assign mul_signed = (op == OpMult) || (op == OpMadd);
  assign prod = {{32{mul_signed & a[31]}}, a} * {{32{mul_signed & b[31]}}, b};

  // Divide on magnitudes, then restore signs (quotient truncates, remainder follows dividend).
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, uq, ur, quot, rem;
  assign div_signed = (op == OpDiv);
  assign a_neg      = div_signed & a[31];
  assign b_neg      = div_signed & b[31];
  assign a_mag      = a_neg ? (32'd0 - a) : a;
  assign b_mag      = (b == 32'd0) ? 32'd1 : (b_neg ? (32'd0 - b) : b);
  assign uq         = a_mag / b_mag;
  assign ur         = a_mag % b_mag;
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign rem        = a_neg ? (32'd0 - ur) : ur;

  always_comb begin
    op_valid = 1'b0;
    case (op)
      OpMult, OpMultu, OpDiv, OpDivu,
      OpMfhi, OpMflo, OpMthi, OpMtlo: op_valid = 1'b1;
`ifdef MDU_MADD_EN
      OpMadd:                          op_valid = 1'b1;
`endif
      default:                         op_valid = 1'b0;
    endcase
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    cnt_d     = cnt_q;
    if (busy) begin
      // Nothing is accepted while busy, so the completion write never collides with MTHI/MTLO.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else begin
      case (op)
        OpMult, OpMultu: begin
          {pend_hi_d, pend_lo_d} = prod;
          cnt_d                  = MulCnt;
        end
        OpDiv, OpDivu: begin
          // Divide by zero re-writes the current HI/LO at completion, leaving them unchanged.
          if (b == 32'd0) begin
            pend_hi_d = hi_q;
            pend_lo_d = lo_q;
          end else begin
            pend_hi_d = rem;
            pend_lo_d = quot;
          end
          cnt_d = DivCnt;
        end
        OpMthi: hi_d = a;
        OpMtlo: lo_d = a;
`ifdef MDU_MADD_EN
        OpMadd: begin
          {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod;
          cnt_d                  = MulCnt;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      cnt_q     <= 4'd0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    bus.out = 32'd0;
    case (op)
      OpMfhi:  bus.out = hi_q;
      OpMflo:  bus.out = lo_q;
      default: bus.out = 32'd0;
    endcase
  end

  assign bus.busy  = busy;
  assign bus.stall = busy & op_valid;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a cycle-level HI/LO model built on plain 64-bit arithmetic,
// compared against the DUT every cycle, plus literal expectations for each scenario.
module tb_mdu_ctrl;
  localparam int MUL = 5;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic reset;
  bit   chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  mdu_ctrl_if bus ();

  mdu_ctrl #(
    .MUL_LAT (MUL),
    .DIV_LAT (DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: HI/LO, pending result and remaining busy cycles.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_wr;
  int          m_rem;
  longint      sa, sb;
  longint unsigned ua, ub;

  function automatic bit known_op(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1) && (o <= 4'd9);
`else
    return (o >= 4'd1) && (o <= 4'd8);
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_wr = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_wr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else begin
      sa = longint'($signed(bus.inA));
      sb = longint'($signed(bus.inB));
      ua = {32'd0, bus.inA};
      ub = {32'd0, bus.inB};
      case (bus.op)
        4'd1: begin {m_phi, m_plo} = sa * sb; m_wr = 1; m_rem = MUL; end
        4'd2: begin {m_phi, m_plo} = ua * ub; m_wr = 1; m_rem = MUL; end
        4'd3: begin
          m_wr = (sb != 0);
          if (m_wr) begin m_plo = 32'(sa / sb); m_phi = 32'(sa % sb); end
          m_rem = DIV;
        end
        4'd4: begin
          m_wr = (ub != 0);
          if (m_wr) begin m_plo = 32'(ua / ub); m_phi = 32'(ua % ub); end
          m_rem = DIV;
        end
        4'd7: m_hi = bus.inA;
        4'd8: m_lo = bus.inA;
`ifdef MDU_MADD_EN
        4'd9: begin {m_phi, m_plo} = {m_hi, m_lo} + sa * sb; m_wr = 1; m_rem = MUL; end
`endif
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 32'(bus.busy), 32'(m_rem != 0));
      check("cyc_stall", 32'(bus.stall), 32'((m_rem != 0) && known_op(bus.op)));
      check("cyc_out", bus.out, (bus.op == 4'd5) ? m_hi : (bus.op == 4'd6) ? m_lo : 32'd0);
      check("cyc_hi", bus.hi, m_hi);
      check("cyc_lo", bus.lo, m_lo);
    end
  end

  // All drives happen 1 time unit after a rising edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op = o; bus.inA = a; bus.inB = b;
    @(posedge clk); #1;
    bus.op = 4'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic count_stall(output int n);
    n = 0;
    while (bus.stall && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) check("stall_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; bus.op = 4'd0; bus.inA = 32'd0; bus.inB = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_out", bus.out, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);

    // MULT -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_busy_cycles", n, 32'd5);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);
    check("model_mult_lo", m_lo, 32'hFFFF_FFFA);
    bus.op = 4'd5; #1;
    check("mfhi_out", bus.out, 32'hFFFF_FFFF);
    bus.op = 4'd0;

    // MULTU 0xFFFFFFFF * 2
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_hi", bus.hi, 32'h0000_0001);
    check("multu_lo", bus.lo, 32'hFFFF_FFFE);
    check("model_multu_hi", m_hi, 32'h0000_0001);

    // DIV -7 / 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_busy_cycles", n, 32'd10);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);
    check("model_div_hi", m_hi, 32'hFFFF_FFFF);

    // DIVU 7 / 0 leaves HI/LO alone
    issue(4'd7, 32'h11, 32'd0);
    issue(4'd8, 32'h22, 32'd0);
    issue(4'd4, 32'd7, 32'd0);
    wait_idle(n);
    check("divz_busy_cycles", n, 32'd10);
    check("divz_hi", bus.hi, 32'h11);
    check("divz_lo", bus.lo, 32'h22);

    // Signed overflow divide
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", bus.lo, 32'h8000_0000);
    check("divovf_hi", bus.hi, 32'h0);
    check("model_divovf_lo", m_lo, 32'h8000_0000);

    // MFLO held across a MULT
    issue(4'd1, 32'd6, 32'd7);
    bus.op = 4'd6;
    count_stall(n);
    check("mflo_stall_cycles", n, 32'd5);
    check("mflo_out", bus.out, 32'h2A);
    bus.op = 4'd0;

    // MTHI held during busy applies only after release
    issue(4'd1, 32'd3, 32'd5);
    bus.op = 4'd7; bus.inA = 32'h1234;
    count_stall(n);
    check("mthi_held_stall", n, 32'd5);
    check("mthi_pre_hi", bus.hi, 32'd0);
    check("mthi_pre_lo", bus.lo, 32'hF);
    @(posedge clk); #1;
    bus.op = 4'd0;
    check("mthi_post_hi", bus.hi, 32'h1234);

    // Reset during an in-flight DIV discards it
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstdiv_busy", 32'(bus.busy), 32'd0);
    check("rstdiv_hi", bus.hi, 32'd0);
    check("rstdiv_lo", bus.lo, 32'd0);
    repeat (12) begin @(posedge clk); #1; end
    check("rstdiv_late_hi", bus.hi, 32'd0);
    check("rstdiv_late_lo", bus.lo, 32'd0);

`ifdef MDU_MADD_EN
    issue(4'd7, 32'd0, 32'd0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd0);
    issue(4'd9, 32'd1, 32'd1);
    wait_idle(n);
    check("madd_busy_cycles", n, 32'd5);
    check("madd_hi", bus.hi, 32'd1);
    check("madd_lo", bus.lo, 32'd0);
`else
    issue(4'd7, 32'd5, 32'd0);
    issue(4'd8, 32'd6, 32'd0);
    bus.op = 4'd9; bus.inA = 32'd1; bus.inB = 32'd1; #1;
    check("op9_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    check("op9_busy", 32'(bus.busy), 32'd0);
    check("op9_hi", bus.hi, 32'd5);
    check("op9_lo", bus.lo, 32'd6);
    issue(4'd1, 32'd2, 32'd2);
    bus.op = 4'd9; #1;
    check("op9_busy_stall", 32'(bus.stall), 32'd0);
    bus.op = 4'd15; #1;
    check("op15_busy_stall", 32'(bus.stall), 32'd0);
    bus.op = 4'd0;
    wait_idle(n);
    check("op9_mult_lo", bus.lo, 32'd4);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
